// File: rtl/apb_fll_ctrl.sv
// APB-to-FLL configuration bridge: decodes APB accesses into a 4-phase
// req/ack handshake towards one of NR_FLLS FLL macros. It also exposes the
// synchronised lock status and a sticky lock-loss register.
module apb_fll_ctrl #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NR_FLLS        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]               pwdata_i,
  output logic                      pready_o,
  output logic [31:0]               prdata_o,
  output logic                      pslverr_o,
  output logic [NR_FLLS-1:0]        fll_req_o,
  output logic                      fll_wrn_o,
  output logic [1:0]                fll_addr_o,
  output logic [31:0]               fll_wdata_o,
  input  logic [NR_FLLS*32-1:0]     fll_rdata_i,
  input  logic [NR_FLLS-1:0]        fll_ack_i,
  input  logic [NR_FLLS-1:0]        fll_lock_i
);

  localparam int SELW = (NR_FLLS > 1) ? $clog2(NR_FLLS) : 1;
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WW   = APB_ADDR_WIDTH - 2;

  localparam logic [WW-1:0] STATUS_W = {WW{1'b1}};
  localparam logic [WW-1:0] LOSS_W   = {{(WW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    RELEASE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0][NR_FLLS-1:0] ack_ff;
  logic [SYNC_STAGES-1:0][NR_FLLS-1:0] lock_ff;
  logic [NR_FLLS-1:0] ack_sync;
  logic [NR_FLLS-1:0] lock_sync;
  logic [NR_FLLS-1:0] lock_q;
  logic [NR_FLLS-1:0] loss_q;
  logic [NR_FLLS-1:0] loss_set;
  logic [NR_FLLS-1:0] loss_clr;

  logic [SELW-1:0] sel_q;
  logic            fll_acc_q;
  logic [CNTW-1:0] cnt;

  logic [WW-1:0]   word;
  logic [SELW-1:0] idx;
  logic            access;
  logic            is_status;
  logic            is_loss;
  logic            in_range;
  logic            unused_addr_bits;

  assign word      = paddr_i[APB_ADDR_WIDTH-1:2];
  assign idx       = paddr_i[4 +: SELW];
  assign access    = psel_i & penable_i;
  assign is_status = (word == STATUS_W);
  assign is_loss   = (word == LOSS_W);
  assign in_range  = (int'(idx) < NR_FLLS);
  assign unused_addr_bits = ^paddr_i[1:0];

  assign ack_sync  = ack_ff[SYNC_STAGES-1];
  assign lock_sync = lock_ff[SYNC_STAGES-1];

  // A falling synchronised lock sets the sticky bit; W1C applies only on the
  // IDLE->RESP edge of a LOCK_LOSS write. OR-ing the set term last lets set win.
  assign loss_set = lock_q & ~lock_sync;
  assign loss_clr = (state == IDLE && access && pwrite_i && is_loss)
                    ? pwdata_i[NR_FLLS-1:0] : '0;

  // Synchronisers for ack/lock, lock edge history and sticky lock-loss register.
  // NOTE: every flop here uses <= so all stages shift on the same edge; a
  // blocking assignment would collapse the synchroniser chain into one flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_ff  <= '0;
      lock_ff <= '0;
      lock_q  <= '0;
      loss_q  <= '0;
    end else begin
      ack_ff  <= {ack_ff[SYNC_STAGES-2:0], fll_ack_i};
      lock_ff <= {lock_ff[SYNC_STAGES-2:0], fll_lock_i};
      lock_q  <= lock_sync;
      loss_q  <= (loss_q & ~loss_clr) | loss_set;
    end
  end

  // Transaction FSM with registered APB response and FLL-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      fll_req_o   <= '0;
      fll_wrn_o   <= 1'b1;
      fll_addr_o  <= '0;
      fll_wdata_o <= '0;
      pready_o    <= 1'b0;
      prdata_o    <= '0;
      pslverr_o   <= 1'b0;
      sel_q       <= '0;
      fll_acc_q   <= 1'b0;
      cnt         <= '0;
    end else begin
      pready_o <= 1'b0;
      case (state)
        IDLE: begin
          fll_req_o   <= '0;
          fll_wrn_o   <= 1'b1;
          fll_addr_o  <= '0;
          fll_wdata_o <= '0;
          if (access) begin
            if (is_status || is_loss) begin
              prdata_o  <= pwrite_i ? 32'h0
                         : (is_status ? 32'(lock_sync) : 32'(loss_q));
              pslverr_o <= pwrite_i & is_status;
              pready_o  <= 1'b1;
              fll_acc_q <= 1'b0;
              state     <= RESP;
            end else if (!in_range) begin
              prdata_o  <= 32'h0;
              pslverr_o <= 1'b1;
              pready_o  <= 1'b1;
              fll_acc_q <= 1'b0;
              state     <= RESP;
            end else if (!ack_sync[idx]) begin
              // A still-high ack (e.g. late ack after timeout) keeps us here.
              sel_q          <= idx;
              fll_wrn_o      <= ~pwrite_i;
              fll_addr_o     <= paddr_i[3:2];
              fll_wdata_o    <= pwdata_i;
              fll_req_o[idx] <= 1'b1;
              fll_acc_q      <= 1'b1;
              cnt            <= '0;
              state          <= REQ;
            end
          end
        end
        REQ: begin
          cnt <= cnt + CNTW'(1);
          if (ack_sync[sel_q]) begin
            prdata_o  <= fll_rdata_i[32*sel_q +: 32];
            pslverr_o <= 1'b0;
            pready_o  <= 1'b1;
            fll_req_o <= '0;
            state     <= RESP;
          end else if (cnt == CNTW'(TIMEOUT_CYCLES - 1)) begin
            prdata_o  <= 32'h0;
            pslverr_o <= 1'b1;
            pready_o  <= 1'b1;
            fll_req_o <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          state <= (fll_acc_q && !pslverr_o) ? RELEASE : IDLE;
        end
        RELEASE: begin
          if (!ack_sync[sel_q]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_fll_ctrl.sv
// Directed self-checking bench for apb_fll_ctrl. A 4-FLL instance with a
// short timeout covers handshake, timeout, late ack, lock and reset cases.
// A 3-FLL instance covers out-of-range decode.
module tb_apb_fll_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        psel4, psel3, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;

  logic         pready4, pslverr4, wrn4;
  logic [31:0]  prdata4, fwdata4;
  logic [3:0]   req4, ack4, lock4;
  logic [1:0]   faddr4;
  logic [127:0] rdata4;

  logic         pready3, pslverr3, wrn3;
  logic [31:0]  prdata3, fwdata3;
  logic [2:0]   req3, ack3, lock3;
  logic [1:0]   faddr3;
  logic [95:0]  rdata3;

  assign rdata4 = {32'h3333_0003, 32'hA5A5_0002, 32'h1111_0001, 32'h1234_5678};
  assign rdata3 = '0;
  assign ack3   = '0;
  assign lock3  = '0;

  apb_fll_ctrl #(.APB_ADDR_WIDTH(12), .NR_FLLS(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .psel_i(psel4), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pready_o(pready4), .prdata_o(prdata4),
    .pslverr_o(pslverr4), .fll_req_o(req4), .fll_wrn_o(wrn4), .fll_addr_o(faddr4),
    .fll_wdata_o(fwdata4), .fll_rdata_i(rdata4), .fll_ack_i(ack4), .fll_lock_i(lock4)
  );

  apb_fll_ctrl #(.APB_ADDR_WIDTH(12), .NR_FLLS(3), .SYNC_STAGES(2), .TIMEOUT_CYCLES(256)) dut3 (
    .clk_i(clk), .rst_i(rst), .psel_i(psel3), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pready_o(pready3), .prdata_o(prdata3),
    .pslverr_o(pslverr3), .fll_req_o(req3), .fll_wrn_o(wrn3), .fll_addr_o(faddr3),
    .fll_wdata_o(fwdata3), .fll_rdata_i(rdata3), .fll_ack_i(ack3), .fll_lock_i(lock3)
  );

  // FLL model: acks on the second edge that sees req, drops ack once req falls.
  logic [3:0] ack_en    = 4'hF;
  logic [3:0] ack_force = 4'h0;
  logic [3:0] ack_mdl   = 4'h0;
  int         ack_cnt [4] = '{default: 0};
  assign ack4 = ack_mdl | ack_force;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req4[i] === 1'b1) begin
        if (ack_cnt[i] == 1) ack_mdl[i] <= ack_en[i];
        else                 ack_cnt[i] <= ack_cnt[i] + 1;
      end else begin
        ack_mdl[i] <= 1'b0;
        ack_cnt[i] <= 0;
      end
    end
  end

  // Monitor of shared FLL outputs while a handshake is in flight.
  logic        mon_en = 1'b0;
  logic        trk_en = 1'b0;
  logic [34:0] mon_exp = '0;
  int          mon_bad = 0;
  logic [3:0]  req_or  = '0;
  logic [2:0]  req3_or = '0;

  always @(negedge clk) begin
    if (mon_en && (req4 != 4'h0 || ack4 != 4'h0) && {wrn4, faddr4, fwdata4} !== mon_exp)
      mon_bad <= mon_bad + 1;
    if (trk_en) req_or <= req_or | req4;
    req3_or <= req3_or | req3;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One APB transfer; called #1 after a clock edge. lat counts edges from the
  // edge where penable is driven high to the one after which pready is seen.
  task automatic apb_xfer(input bit to3, input logic [11:0] a, input bit wr,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic err, output int lat);
    psel4 = !to3; psel3 = to3; paddr = a; pwrite = wr; pwdata = wd; penable = 1'b0;
    rd = 'x; err = 1'bx; lat = -1;
    @(posedge clk); #1 penable = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); #1;
      if ((to3 ? pready3 : pready4) === 1'b1) begin
        lat = n;
        rd  = to3 ? prdata3 : prdata4;
        err = to3 ? pslverr3 : pslverr4;
        break;
      end
    end
    psel4 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
  endtask

  task automatic xfer_chk(input string tag, input bit to3, input logic [11:0] a,
                          input bit wr, input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic        err;
    int          lat;
    apb_xfer(to3, a, wr, wd, rd, err, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_apb"}, {pready4, pslverr4, prdata4}, 64'h0);
    check({tag, "_fll"}, {req4, wrn4, faddr4, fwdata4}, {4'h0, 1'b1, 2'b00, 32'h0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; psel4 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; lock4 = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Write 0xDEADBEEF to FLL 2, register 1.
    mon_exp = {1'b0, 2'd1, 32'hDEAD_BEEF}; mon_en = 1'b1; trk_en = 1'b1;
    xfer_chk("wr_fll2", 1'b0, 12'h024, 1'b1, 32'hDEAD_BEEF, 32'hA5A5_0002, 1'b0, 6);
    repeat (6) @(posedge clk);
    #1;
    trk_en = 1'b0;
    check("wr_req_onehot", req_or, 4'b0100);
    check("idle_shared", {wrn4, faddr4, fwdata4}, {1'b1, 2'b00, 32'h0});

    // Read FLL 0, register 3, then back-to-back read held off by the release.
    mon_exp = {1'b1, 2'd3, 32'h0};
    xfer_chk("rd_fll0", 1'b0, 12'h00C, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 6);
    xfer_chk("rd_b2b", 1'b0, 12'h00C, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 9);
    repeat (6) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("shared_stable", 64'(mon_bad), 64'd0);

    // Timeout on FLL 1, then a late ack that stays high for a while.
    ack_en[1] = 1'b0;
    xfer_chk("timeout", 1'b0, 12'h010, 1'b0, 32'h0, 32'h0, 1'b1, 17);
    ack_force[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    xfer_chk("other_fll", 1'b0, 12'h020, 1'b1, 32'h0000_CAFE, 32'hA5A5_0002, 1'b0, 6);
    repeat (6) @(posedge clk);
    #1;
    ack_en[1] = 1'b1;
    fork
      xfer_chk("stalled", 1'b0, 12'h010, 1'b0, 32'h0, 32'h1111_0001, 1'b0, 11);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("stall_no_req", req4, 4'h0);
        ack_force[1] = 1'b0;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Out-of-range FLL and LOCK_STATUS write on the 3-FLL instance.
    xfer_chk("oor", 1'b1, 12'h030, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    xfer_chk("st_wr3", 1'b1, 12'hFFC, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    @(posedge clk);
    #1;
    check("oor_no_req", req3_or, 3'b000);
    check("dut3_idle", {req3, wrn3, faddr3, fwdata3}, {3'b000, 1'b1, 2'b00, 32'h0});

    // Lock status and sticky lock loss.
    lock4 = 4'hF;
    repeat (5) @(posedge clk);
    #1;
    xfer_chk("loss_none", 1'b0, 12'hFF8, 1'b0, 32'h0, 32'h0, 1'b0, 1);
    lock4 = 4'b1101;
    repeat (5) @(posedge clk);
    #1;
    xfer_chk("lock_st", 1'b0, 12'hFFC, 1'b0, 32'h0, 32'hD, 1'b0, 1);
    xfer_chk("loss_rd", 1'b0, 12'hFF8, 1'b0, 32'h0, 32'h2, 1'b0, 1);
    lock4[3] = 1'b0;
    @(posedge clk);
    #1;
    xfer_chk("loss_w1c", 1'b0, 12'hFF8, 1'b1, 32'h2, 32'h0, 1'b0, 1);
    xfer_chk("loss_rd2", 1'b0, 12'hFF8, 1'b0, 32'h0, 32'h8, 1'b0, 1);
    lock4[3] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    lock4[3] = 1'b0;
    @(posedge clk);
    #1;
    xfer_chk("loss_setwin", 1'b0, 12'hFF8, 1'b1, 32'h8, 32'h0, 1'b0, 1);
    xfer_chk("loss_rd3", 1'b0, 12'hFF8, 1'b0, 32'h0, 32'h8, 1'b0, 1);
    xfer_chk("loss_clr", 1'b0, 12'hFF8, 1'b1, 32'h8, 32'h0, 1'b0, 1);
    xfer_chk("loss_rd4", 1'b0, 12'hFF8, 1'b0, 32'h0, 32'h0, 1'b0, 1);
    xfer_chk("st_wr4", 1'b0, 12'hFFC, 1'b1, 32'hF, 32'h0, 1'b1, 1);
    xfer_chk("lock_st2", 1'b0, 12'hFFC, 1'b0, 32'h0, 32'h5, 1'b0, 1);

    // Reset while in REQ, then a fresh access.
    ack_en[1] = 1'b0;
    psel4 = 1'b1; paddr = 12'h010; pwrite = 1'b1; pwdata = 32'h55;
    @(posedge clk);
    #1 penable = 1'b1;
    @(posedge clk);
    #1;
    check("req_before_rst", req4, 4'b0010);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst");
    rst = 1'b0; psel4 = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    ack_en[1] = 1'b1;
    @(posedge clk);
    #1;
    xfer_chk("post_rst", 1'b0, 12'h014, 1'b1, 32'h0000_1234, 32'h1111_0001, 1'b0, 6);
    repeat (6) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
